alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
- Single-requester front end for TotalALU. Accepts one operation at a time over a valid/ready request channel and drives the ALU's Signal, dataA, dataB and reset pins.
- Runs the multi-cycle MULTU sequence: start pulse, fixed wait, then MFHI and MFLO reads. Returns the result over a valid/ready response channel.
- Sits between the instruction issue logic and TotalALU. It replaces hand-timed bench sequencing of the ALU.

Parameters:
- MUL_CYCLES, 33: cycles waited after the multiply start pulse before HI is read; must be ≥1.
- DATA_W, 32: operand and result width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- req_op  in  6  function code: 36 AND, 37 OR, 32 ADD, 34 SUB, 42 SLT, 2 SRL, 25 MULTU, 16 MFHI, 18 MFLO.
- req_a  in  DATA_W  operand A.
- req_b  in  DATA_W  operand B.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes the response.
- rsp_data  out  DATA_W  result; LO word for MULTU.
- rsp_hi  out  DATA_W  HI word for MULTU; 0 for all other ops.
- rsp_err  out  1  request op code unsupported.
- alu_signal  out  6  to TotalALU Signal.
- alu_dataA  out  DATA_W  to TotalALU dataA.
- alu_dataB  out  DATA_W  to TotalALU dataB.
- alu_reset  out  1  to TotalALU reset; active-high multiply start pulse.
- alu_out  in  DATA_W  from TotalALU Output.
- busy  out  1  high in every state except IDLE.

Behaviour:
- All outputs are registered. Reset value of every output is 0, except req_ready, which is 1 while in IDLE after reset.
- States: IDLE, EXEC, MUL_START, MUL_WAIT, RD_HI, RD_LO, RESP.
- IDLE
  - req_ready=1.
  - On the edge where req_valid && req_ready, latch req_op, req_a and req_b into alu_signal, alu_dataA and alu_dataB.
  - op 25 -> MUL_START; supported single-cycle op -> EXEC; unsupported op -> RESP.
  - For an unsupported op: alu_* outputs are left unchanged, rsp_err=1, rsp_data=0, rsp_hi=0.
- EXEC
  - One cycle.
  - At the ending edge, capture alu_out into rsp_data, set rsp_hi=0 and rsp_err=0, go RESP.
  - Latency: accept at edge k -> rsp_valid=1 after edge k+1.
- MUL_START
  - alu_reset=1 for exactly this one cycle.
  - Load counter with MUL_CYCLES, go MUL_WAIT.
- MUL_WAIT
  - Counter decrements each cycle.
  - When the counter reaches 0: drive alu_signal=16, go RD_HI.
  - Counter width is clog2(MUL_CYCLES+1).
- RD_HI
  - At the ending edge, capture alu_out into rsp_hi, drive alu_signal=18, go RD_LO.
- RD_LO
  - At the ending edge, capture alu_out into rsp_data, set rsp_err=0, go RESP.
  - MULTU latency: accept at edge k -> rsp_valid=1 after edge k+MUL_CYCLES+3 (k+36 at default).
- RESP
  - rsp_valid=1; rsp_data, rsp_hi and rsp_err are held stable.
  - req_ready=0; req_valid is ignored.
  - On an edge with rsp_ready=1: rsp_valid goes to 0, go IDLE. No same-cycle accept of a new request.
  - Minimum issue interval is 3 cycles for single-cycle ops.
- MFHI/MFLO (16/18) issued by the requester are ordinary single-cycle EXEC ops that return the ALU's current HI or LO.
- In IDLE and RESP, alu_signal, alu_dataA and alu_dataB hold their last driven values.
- alu_reset is never asserted outside MUL_START.
- Reset asserted at any time, including mid-multiply:
  - Immediate return to IDLE; counter cleared; all outputs take their reset values.
  - An in-flight operation is discarded and produces no response.
  - alu_reset is 0 while reset is held.
- Arithmetic is the ALU's. The sequencer never modifies operands or results; width is DATA_W throughout.

Test Plan:
- Reset: hold reset low 2 cycles with req_valid=1 -> all outputs 0, no accept; after release, req_ready=1.
- ADD 7,5 accepted at edge k -> during the next cycle alu_signal=32, alu_dataA=7, alu_dataB=5; after edge k+1, rsp_valid=1, rsp_data=12, rsp_hi=0, rsp_err=0.
- MULTU 0x00010000 × 0x00010000 accepted at edge k:
  - alu_reset high exactly one cycle.
  - alu_signal=16 then 18 in the final two cycles.
  - rsp_valid=1 after edge k+36; rsp_hi=1, rsp_data=0.
- SUB 3,5 with rsp_ready held low 5 cycles -> rsp_data=0xFFFFFFFE stays stable, req_ready=0 and a pending req_valid is not accepted; req_ready=1 on the cycle after the rsp_ready handshake.
- Unsupported op 63 -> after edge k+1, rsp_err=1, rsp_data=0; alu_signal unchanged; alu_reset never asserted.
- Reset asserted with the MULTU counter at 10:
  - Immediately: busy=0, rsp_valid=0, alu_reset=0.
  - No response after release.
  - Following OR 0xF0,0x0F -> rsp_data=0xFF.

Source files
------------

// File: rtl/alu_sequencer.sv
// Valid/ready front end for TotalALU: one op at a time, runs MULTU start/wait/MFHI/MFLO.
// Latency: single-cycle op 1 edge to rsp_valid, MULTU MUL_CYCLES+3 edges; response held until rsp_ready.
module alu_sequencer #(
    parameter int MUL_CYCLES = 33,
    parameter int DATA_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [5:0]        req_op,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [DATA_W-1:0] rsp_hi,
    output logic              rsp_err,
    output logic [5:0]        alu_signal,
    output logic [DATA_W-1:0] alu_dataA,
    output logic [DATA_W-1:0] alu_dataB,
    output logic              alu_reset,
    input  logic [DATA_W-1:0] alu_out,
    output logic              busy
);

    localparam int CNT_W = $clog2(MUL_CYCLES + 1);

    localparam logic [5:0] OP_AND   = 6'd36;
    localparam logic [5:0] OP_OR    = 6'd37;
    localparam logic [5:0] OP_ADD   = 6'd32;
    localparam logic [5:0] OP_SUB   = 6'd34;
    localparam logic [5:0] OP_SLT   = 6'd42;
    localparam logic [5:0] OP_SRL   = 6'd2;
    localparam logic [5:0] OP_MULTU = 6'd25;
    localparam logic [5:0] OP_MFHI  = 6'd16;
    localparam logic [5:0] OP_MFLO  = 6'd18;

    typedef enum logic [2:0] {
        IDLE,
        EXEC,
        MUL_START,
        MUL_WAIT,
        RD_HI,
        RD_LO,
        RESP
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               req_ready_d, rsp_valid_d, rsp_err_d, alu_reset_d, busy_d;
    logic [DATA_W-1:0]  rsp_data_d, rsp_hi_d, alu_dataA_d, alu_dataB_d;
    logic [5:0]         alu_signal_d;
    logic               single_op;

    always_comb begin
        single_op = 1'b0;
        case (req_op)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_SRL, OP_MFHI, OP_MFLO: single_op = 1'b1;
            default: single_op = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Every output is the registered image of its _d value.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        req_ready_d  = req_ready;
        rsp_valid_d  = rsp_valid;
        rsp_data_d   = rsp_data;
        rsp_hi_d     = rsp_hi;
        rsp_err_d    = rsp_err;
        alu_signal_d = alu_signal;
        alu_dataA_d  = alu_dataA;
        alu_dataB_d  = alu_dataB;
        alu_reset_d  = 1'b0;
        busy_d       = busy;

        case (state_q)
            IDLE: begin
                req_ready_d = 1'b1;
                busy_d      = 1'b0;
                if (req_valid && req_ready) begin
                    req_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    if (req_op == OP_MULTU) begin
                        alu_signal_d = req_op;
                        alu_dataA_d  = req_a;
                        alu_dataB_d  = req_b;
                        alu_reset_d  = 1'b1;
                        state_d      = MUL_START;
                    end else if (single_op) begin
                        alu_signal_d = req_op;
                        alu_dataA_d  = req_a;
                        alu_dataB_d  = req_b;
                        state_d      = EXEC;
                    end else begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_data_d  = '0;
                        rsp_hi_d    = '0;
                        state_d     = RESP;
                    end
                end
            end
            EXEC: begin
                rsp_data_d  = alu_out;
                rsp_hi_d    = '0;
                rsp_err_d   = 1'b0;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            MUL_START: begin
                cnt_d   = CNT_W'(MUL_CYCLES);
                state_d = MUL_WAIT;
            end
            MUL_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                // Leave on the edge that takes the counter to zero.
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d        = '0;
                    alu_signal_d = OP_MFHI;
                    state_d      = RD_HI;
                end
            end
            RD_HI: begin
                rsp_hi_d     = alu_out;
                alu_signal_d = OP_MFLO;
                state_d      = RD_LO;
            end
            RD_LO: begin
                rsp_data_d  = alu_out;
                rsp_err_d   = 1'b0;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
                rsp_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q      <= '0;
            req_ready  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_hi     <= '0;
            rsp_err    <= 1'b0;
            alu_signal <= '0;
            alu_dataA  <= '0;
            alu_dataB  <= '0;
            alu_reset  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            req_ready  <= req_ready_d;
            rsp_valid  <= rsp_valid_d;
            rsp_data   <= rsp_data_d;
            rsp_hi     <= rsp_hi_d;
            rsp_err    <= rsp_err_d;
            alu_signal <= alu_signal_d;
            alu_dataA  <= alu_dataA_d;
            alu_dataB  <= alu_dataB_d;
            alu_reset  <= alu_reset_d;
            busy       <= busy_d;
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural TotalALU stand-in driving alu_out.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [5:0]  req_op = '0;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic [31:0] rsp_hi;
    logic        rsp_err;
    logic [5:0]  alu_signal;
    logic [31:0] alu_dataA;
    logic [31:0] alu_dataB;
    logic        alu_reset;
    logic [31:0] alu_out;
    logic        busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_sequencer #(.MUL_CYCLES(33), .DATA_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_hi     (rsp_hi),
        .rsp_err    (rsp_err),
        .alu_signal (alu_signal),
        .alu_dataA  (alu_dataA),
        .alu_dataB  (alu_dataB),
        .alu_reset  (alu_reset),
        .alu_out    (alu_out),
        .busy       (busy)
    );

    // TotalALU stand-in: product latched on the start pulse, MFHI/MFLO read it back.
    logic [31:0] hi_r = '0;
    logic [31:0] lo_r = '0;
    always @(posedge clk) begin
        if (alu_reset) {hi_r, lo_r} <= 64'(alu_dataA) * 64'(alu_dataB);
    end

    always_comb begin
        alu_out = '0;
        case (alu_signal)
            6'd36: alu_out = alu_dataA & alu_dataB;
            6'd37: alu_out = alu_dataA | alu_dataB;
            6'd32: alu_out = alu_dataA + alu_dataB;
            6'd34: alu_out = alu_dataA - alu_dataB;
            6'd42: alu_out = {31'd0, $signed(alu_dataA) < $signed(alu_dataB)};
            6'd2:  alu_out = alu_dataA >> alu_dataB[4:0];
            6'd16: alu_out = hi_r;
            6'd18: alu_out = lo_r;
            default: alu_out = '0;
        endcase
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        int w;
        w = 0;
        while (!req_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!req_ready) check("issue_timeout", 64'(req_ready), 64'd1);
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int c);
        c = 0;
        while (!rsp_valid && c < 100) begin
            @(negedge clk);
            c++;
        end
    endtask

    task automatic ack();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("ack_vld", 64'(rsp_valid), 64'd0);
        check("ack_rdy", 64'(req_ready), 64'd1);
        check("ack_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        int c;
        int pulses;
        int seen;
        logic [5:0] sig34;
        logic [5:0] sig35;

        // Reset held with a request pending
        req_valid = 1'b1;
        req_op    = 6'd32;
        req_a     = 32'd7;
        req_b     = 32'd5;
        repeat (2) @(negedge clk);
        check("rst_rdy", 64'(req_ready), 64'd0);
        check("rst_vld", 64'(rsp_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_sig", 64'(alu_signal), 64'd0);
        check("rst_a", 64'(alu_dataA), 64'd0);
        check("rst_arst", 64'(alu_reset), 64'd0);
        check("rst_data", 64'({rsp_data, rsp_hi}), 64'd0);
        req_valid = 1'b0;
        reset     = 1'b1;
        @(negedge clk);
        check("post_rst_rdy", 64'(req_ready), 64'd1);

        // ADD 7,5
        issue(6'd32, 32'd7, 32'd5);
        check("add_sig", 64'(alu_signal), 64'd32);
        check("add_a", 64'(alu_dataA), 64'd7);
        check("add_b", 64'(alu_dataB), 64'd5);
        check("add_busy", 64'(busy), 64'd1);
        wait_rsp(c);
        check("add_lat", 64'(c), 64'd1);
        check("add_data", 64'(rsp_data), 64'd12);
        check("add_hi", 64'(rsp_hi), 64'd0);
        check("add_err", 64'(rsp_err), 64'd0);
        ack();

        // MULTU 0x10000 * 0x10000
        issue(6'd25, 32'h0001_0000, 32'h0001_0000);
        pulses = alu_reset ? 1 : 0;
        sig34  = '0;
        sig35  = '0;
        c = 0;
        while (!rsp_valid && c < 100) begin
            @(negedge clk);
            c++;
            if (alu_reset) pulses++;
            if (c == 34) sig34 = alu_signal;
            if (c == 35) sig35 = alu_signal;
        end
        check("mul_lat", 64'(c), 64'd36);
        check("mul_pulses", 64'(pulses), 64'd1);
        check("mul_sig_hi", 64'(sig34), 64'd16);
        check("mul_sig_lo", 64'(sig35), 64'd18);
        check("mul_hi", 64'(rsp_hi), 64'd1);
        check("mul_lo", 64'(rsp_data), 64'd0);
        check("mul_err", 64'(rsp_err), 64'd0);
        ack();

        // MFHI as a plain single-cycle op
        issue(6'd16, 32'd0, 32'd0);
        wait_rsp(c);
        check("mfhi_lat", 64'(c), 64'd1);
        check("mfhi_data", 64'(rsp_data), 64'd1);
        ack();

        // SUB 3,5 with response backpressure and a pending request
        issue(6'd34, 32'd3, 32'd5);
        wait_rsp(c);
        check("sub_data", 64'(rsp_data), 64'hFFFF_FFFE);
        req_op    = 6'd32;
        req_a     = 32'd1;
        req_b     = 32'd1;
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_data", 64'(rsp_data), 64'hFFFF_FFFE);
            check("hold_vld", 64'(rsp_valid), 64'd1);
            check("hold_rdy", 64'(req_ready), 64'd0);
            check("hold_sig", 64'(alu_signal), 64'd34);
        end
        req_valid = 1'b0;
        ack();

        // AND and signed SLT
        issue(6'd36, 32'h0000_F0F0, 32'h0000_FF00);
        wait_rsp(c);
        check("and_data", 64'(rsp_data), 64'h0000_F000);
        ack();
        issue(6'd42, 32'hFFFF_FFFF, 32'd1);
        wait_rsp(c);
        check("slt_data", 64'(rsp_data), 64'd1);
        ack();

        // Unsupported op 63
        issue(6'd63, 32'hAA, 32'hBB);
        check("unsup_arst0", 64'(alu_reset), 64'd0);
        @(negedge clk);
        check("unsup_vld", 64'(rsp_valid), 64'd1);
        check("unsup_err", 64'(rsp_err), 64'd1);
        check("unsup_data", 64'(rsp_data), 64'd0);
        check("unsup_hi", 64'(rsp_hi), 64'd0);
        check("unsup_sig", 64'(alu_signal), 64'd42);
        check("unsup_a", 64'(alu_dataA), 64'hFFFF_FFFF);
        check("unsup_arst1", 64'(alu_reset), 64'd0);
        ack();

        // Reset mid-multiply, counter at 10 after edge k+24
        issue(6'd25, 32'd2, 32'd3);
        repeat (24) @(negedge clk);
        check("mid_busy_pre", 64'(busy), 64'd1);
        reset = 1'b0;
        #1;
        check("mid_busy", 64'(busy), 64'd0);
        check("mid_vld", 64'(rsp_valid), 64'd0);
        check("mid_arst", 64'(alu_reset), 64'd0);
        check("mid_rdy", 64'(req_ready), 64'd0);
        @(negedge clk);
        @(negedge clk);
        check("mid_arst_hold", 64'(alu_reset), 64'd0);
        reset = 1'b1;
        seen = 0;
        repeat (50) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        check("mid_no_rsp", 64'(seen), 64'd0);
        check("mid_rdy_after", 64'(req_ready), 64'd1);

        // OR after the aborted multiply
        issue(6'd37, 32'hF0, 32'h0F);
        wait_rsp(c);
        check("or_lat", 64'(c), 64'd1);
        check("or_data", 64'(rsp_data), 64'hFF);
        ack();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
